msb_period_meter: RTL
=====================

// Module: msb_period_meter
// PURPOSE
//   Receive-side counterpart to the accumulator MSB output: measures the period of a single-bit
//   square wave on sig_in.
//   Counts clk cycles between consecutive synchronised rising edges.
//   Delivers each result through a valid/ready port, with saturation and overrun flags.
//   Sits on the input side of a tile; sig_in may be asynchronous to clk.
// PARAMETERS
//   CNT_WIDTH    16  width of period counter and result (>=2)
//   SYNC_STAGES   2  synchroniser flops on sig_in (>=2)
// PORTS
//   clk           in   1          system clock, all state on rising edge
//   rst           in   1          asynchronous, active-high reset
//   sig_in        in   1          measured signal, asynchronous
//   enable        in   1          1 = measure; 0 = abort the current measurement, go to IDLE
//   clear         in   1          synchronous: drop pending result, clear overrun, go to IDLE
//   period_o      out  CNT_WIDTH  measured period in clk cycles
//   period_sat    out  1          result saturated (true period >= 2^CNT_WIDTH-1)
//   period_valid  out  1          result pending
//   period_ready  in   1          consumer accepts when valid && ready
//   overrun       out  1          sticky: a completed result was discarded
//   high_o        out  CNT_WIDTH  high time in clk cycles (only with MSB_PERIOD_METER_DUTY_EN)
// BEHAVIOUR
//   - Reset: all outputs 0, counter 0, synchroniser flops 0, state IDLE.
//   - Edge detection: rise = sync_q & ~sync_q_d. Detection is SYNC_STAGES+1 clk after a sig_in edge.
//   - States:
//     - IDLE: cnt=0. On enable && rise: go to MEASURE, cnt<=1.
//     - MEASURE, each cycle without rise: cnt<=cnt+1, saturating at all-ones; sat flag set on reaching all-ones.
//     - MEASURE, on rise: complete the result (period=cnt, sat=flag), cnt<=1, flag<=0, stay in MEASURE.
//     - enable=0 in any state: go to IDLE, cnt=0, flag=0. A pending result is kept.
//     - clear=1: go to IDLE, period_valid<=0, overrun<=0. clear has priority over enable and over a completion.
//   - Result port:
//     - On completion with !period_valid or (period_valid && period_ready): load period_o and period_sat,
//       period_valid<=1, visible the cycle after the rise.
//     - On completion with period_valid && !period_ready: discard the new result, overrun<=1,
//       period_o stays stable.
//     - valid && ready with no completion that cycle: period_valid<=0. period_o holds its last value.
//     - period_o and period_sat never change while valid && !ready.
//   - Widths: the counter never wraps.
//     A period of P clk (P < 2^CNT_WIDTH-1) gives period_o=P, sat=0.
//     Otherwise period_o = all-ones, sat=1.
//   - Reset mid-operation clears everything asynchronously. The first result after release needs two rising edges.
// CONFIGURATION
//   MSB_PERIOD_METER_DUTY_EN defined:
//     - A second saturating counter counts cycles with sync_q=1 since the last rise.
//     - high_o loads together with period_o and is held under the same rules.
//   MSB_PERIOD_METER_DUTY_EN undefined:
//     - No second counter; high_o is driven 0.
// STRUCTURE
//   - Package msb_period_meter_pkg:
//     - state enum {ST_IDLE, ST_MEASURE}.
//     - Default CNT_WIDTH and SYNC_STAGES localparams.
//   - Sub-module bit_sync_edge (SYNC_STAGES):
//     - Async-reset synchroniser chain.
//     - Outputs: sync level and single-cycle rise pulse.
//   - Top level: FSM, saturating counter(s), result register and handshake.
// TESTING
//   1. Square wave, period 10 clk (5 high/5 low), enable=1, ready=1.
//      -> First valid 1 clk after the 2nd detected rise; period_o=10, sat=0 for every result.
//   2. CNT_WIDTH=8, period 300 clk.
//      -> period_o=255, period_sat=1; then period 20 -> period_o=20, sat=0.
//   3. Period 10, ready=0 across 3 rises.
//      -> valid stays 1, period_o=10 stable, overrun=1.
//      -> ready=1 for one cycle -> valid drops, overrun stays 1.
//      -> clear -> overrun=0.
//   4. enable=0 for 3 clk mid-period, then enable=1 (period 10).
//      -> No result until two new rises after re-enable; the next result is 10.
//   5. rst pulsed mid-count, asynchronous to clk.
//      -> All outputs 0 immediately; measurement restarts cleanly.
//   6. MSB_PERIOD_METER_DUTY_EN, 3 high/7 low.
//      -> period_o=10, high_o=3. Without the macro -> high_o=0.

Source files
------------

// File: rtl/msb_period_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module : msb_period_meter_pkg
// Purpose: Shared types and default sizes for the MSB period meter.
//          Holds the measurement state encoding and the default counter and
//          synchroniser sizes used by msb_period_meter and bit_sync_edge.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package msb_period_meter_pkg;

    localparam int c_DEFAULT_CNT_WIDTH   = 16;
    localparam int c_DEFAULT_SYNC_STAGES = 2;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

endpackage : msb_period_meter_pkg
`default_nettype wire

// File: rtl/bit_sync_edge.sv
`default_nettype none
// ============================================================================
// Module : bit_sync_edge
// Purpose: Brings an asynchronous single-bit signal into the clk domain and
//          produces a one-cycle pulse on each synchronised rising edge.
// Ports  : clk     in  system clock
//          rst     in  asynchronous active-high reset (clears all flops)
//          async_i in  asynchronous input bit
//          sync_o  out synchronised level (last synchroniser stage)
//          rise_o  out single-cycle pulse, sync_o rose this cycle
// Rev    : 1.0  initial release
// ============================================================================
module bit_sync_edge
    import msb_period_meter_pkg::*;
#(
    parameter int SYNC_STAGES = c_DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_chain_q;
    logic                   sync_dly_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_chain_q <= '0;
            sync_dly_q   <= 1'b0;
        end else begin
            sync_chain_q <= {sync_chain_q[SYNC_STAGES-2:0], async_i};
            sync_dly_q   <= sync_chain_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_chain_q[SYNC_STAGES-1];
    // Compare against the one-cycle-delayed copy so each edge yields one pulse.
    assign rise_o = sync_chain_q[SYNC_STAGES-1] & ~sync_dly_q;

endmodule : bit_sync_edge
`default_nettype wire

// File: rtl/msb_period_meter.sv
`default_nettype none
// ============================================================================
// Module : msb_period_meter
// Purpose: Measures the period (in clk cycles) of a square wave on sig_in
//          between consecutive synchronised rising edges and presents each
//          result on a valid/ready port with saturation and overrun flags.
//          Optional build macro MSB_PERIOD_METER_DUTY_EN adds a high-time
//          counter reported on high_o; without it high_o is tied to 0.
// Ports  : clk           in  system clock
//          rst           in  asynchronous active-high reset
//          sig_in        in  measured signal (asynchronous)
//          enable        in  1 = measure, 0 = abort and idle
//          clear         in  drop pending result, clear overrun, idle
//          period_o      out measured period
//          period_sat    out period saturated at all-ones
//          period_valid  out result pending
//          period_ready  in  consumer accepts on valid && ready
//          overrun       out sticky: a completed result was discarded
//          high_o        out high time of the reported period
// Rev    : 1.0  initial release
// ============================================================================
module msb_period_meter
    import msb_period_meter_pkg::*;
#(
    parameter int CNT_WIDTH   = c_DEFAULT_CNT_WIDTH,
    parameter int SYNC_STAGES = c_DEFAULT_SYNC_STAGES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sig_in,
    input  logic                 enable,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] period_o,
    output logic                 period_sat,
    output logic                 period_valid,
    input  logic                 period_ready,
    output logic                 overrun,
    output logic [CNT_WIDTH-1:0] high_o
);

    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic w_sync;
    logic w_rise;

    bit_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (sig_in),
        .sync_o  (w_sync),
        .rise_o  (w_rise)
    );

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 flag_q, flag_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic                 psat_q, psat_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;
    logic                 w_complete;
    logic                 w_load;

    // ------------------------------------------------------------------
    // Measurement FSM and saturating period counter
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        flag_d     = flag_q;
        w_complete = 1'b0;
        // clear outranks enable, and both outrank any edge this cycle.
        if (clear || !enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            flag_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d  = '0;
                    flag_d = 1'b0;
                    if (w_rise) begin
                        state_d = ST_MEASURE;
                        cnt_d   = c_CNT_ONE;
                    end
                end
                ST_MEASURE: begin
                    if (w_rise) begin
                        w_complete = 1'b1;
                        cnt_d      = c_CNT_ONE;
                        flag_d     = 1'b0;
                    end else begin
                        if (cnt_q != c_CNT_MAX) begin
                            cnt_d = cnt_q + c_CNT_ONE;
                        end
                        flag_d = flag_q | (cnt_d == c_CNT_MAX);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    flag_d  = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Result register and handshake. A completion may load in the same
    // cycle the previous result is accepted; otherwise a held result is
    // protected and the newcomer is dropped with overrun set.
    // ------------------------------------------------------------------
    assign w_load = w_complete & (~valid_q | period_ready);

    always_comb begin
        period_d  = period_q;
        psat_d    = psat_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (clear) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end else if (w_complete) begin
            if (w_load) begin
                period_d = cnt_q;
                psat_d   = flag_q;
                valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && period_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            flag_q    <= 1'b0;
            period_q  <= '0;
            psat_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            flag_q    <= flag_d;
            period_q  <= period_d;
            psat_q    <= psat_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign period_o     = period_q;
    assign period_sat   = psat_q;
    assign period_valid = valid_q;
    assign overrun      = overrun_q;

`ifdef MSB_PERIOD_METER_DUTY_EN
    // ------------------------------------------------------------------
    // High-time counter: the rise cycle itself is the first high cycle.
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] hcnt_q, hcnt_d;
    logic [CNT_WIDTH-1:0] high_q, high_d;

    always_comb begin
        hcnt_d = hcnt_q;
        high_d = high_q;
        if (clear || !enable) begin
            hcnt_d = '0;
        end else if (w_rise) begin
            hcnt_d = c_CNT_ONE;
        end else if (state_q == ST_IDLE) begin
            hcnt_d = '0;
        end else if (w_sync && (hcnt_q != c_CNT_MAX)) begin
            hcnt_d = hcnt_q + c_CNT_ONE;
        end
        if (!clear && w_load) begin
            high_d = hcnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q <= '0;
            high_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            high_q <= high_d;
        end
    end

    assign high_o = high_q;
`else
    // Level output is only needed by the high-time counter.
    logic w_unused_sync;
    assign w_unused_sync = w_sync;
    assign high_o        = '0;
`endif

endmodule : msb_period_meter
`default_nettype wire
